// File: rtl/square_animator.sv
// square_animator: animates N squares (raster wrap or edge bounce) and
// reports per-pixel coverage with the index of the lowest covering square.
// Optional build macro SQUARE_COLLIDE_EN enables the per-frame overlap flag;
// with it undefined, collide is tied low.
module square_animator #(
    parameter int unsigned CORDW   = 12,
    parameter int unsigned N       = 4,
    parameter int unsigned Q_SIZE  = 96,
    parameter int unsigned H_RES   = 1920,
    parameter int unsigned V_RES   = 1080,
    parameter int unsigned SPEED_X = 12,
    parameter int unsigned SPEED_Y = 8,
    parameter int unsigned MODE    = 0,
    localparam int unsigned IDW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_pix,
    input  logic             rst,
    input  logic             frame,
    input  logic             pause,
    input  logic [CORDW-1:0] sx,
    input  logic [CORDW-1:0] sy,
    input  logic             de,
    output logic             draw,
    output logic [IDW-1:0]   draw_id,
    output logic             collide
);

    // One extra bit so sums and limits never wrap
    localparam int unsigned CW1 = CORDW + 1;
    localparam logic [CW1-1:0] X_MAX = CW1'(H_RES - Q_SIZE);
    localparam logic [CW1-1:0] Y_MAX = CW1'(V_RES - Q_SIZE);
    localparam logic [CW1-1:0] SPX   = CW1'(SPEED_X);
    localparam logic [CW1-1:0] SPY   = CW1'(SPEED_Y);
    localparam logic [CW1-1:0] Q_W   = CW1'(Q_SIZE);

    logic [CW1-1:0] sx_w;
    logic [CW1-1:0] sy_w;
    logic [N-1:0]   hit;
    logic [IDW-1:0] win_id;
    logic           any_hit;
    logic           overlap;

    assign sx_w = CW1'(sx);
    assign sy_w = CW1'(sy);

    for (genvar g = 0; g < N; g++) begin : g_sq
        localparam int unsigned X0 = (2 * g * Q_SIZE) % (H_RES - Q_SIZE + 1);
        localparam int unsigned Y0 = (g * Q_SIZE) % (V_RES - Q_SIZE + 1);

        logic [CORDW-1:0] qx, qy, qx_nxt, qy_nxt;
        logic             dir_x, dir_y, dir_x_nxt, dir_y_nxt;  // 1 = moving negative
        logic [CW1-1:0]   x_w, y_w;

        assign x_w = CW1'(qx);
        assign y_w = CW1'(qy);

        // Next position/direction for one frame step
        always_comb begin
            qx_nxt    = qx;
            qy_nxt    = qy;
            dir_x_nxt = dir_x;
            dir_y_nxt = dir_y;
            if (MODE == 0) begin
                if (x_w >= X_MAX) begin
                    qx_nxt = '0;
                    qy_nxt = (y_w >= Y_MAX) ? '0 : CORDW'(y_w + Q_W);
                end else begin
                    qx_nxt = CORDW'(x_w + SPX);
                end
            end else begin
                if (!dir_x) begin
                    if (x_w + SPX > X_MAX) begin
                        qx_nxt    = CORDW'(X_MAX);
                        dir_x_nxt = 1'b1;
                    end else begin
                        qx_nxt = CORDW'(x_w + SPX);
                    end
                end else if (x_w < SPX) begin
                    qx_nxt    = '0;
                    dir_x_nxt = 1'b0;
                end else begin
                    qx_nxt = CORDW'(x_w - SPX);
                end
                if (!dir_y) begin
                    if (y_w + SPY > Y_MAX) begin
                        qy_nxt    = CORDW'(Y_MAX);
                        dir_y_nxt = 1'b1;
                    end else begin
                        qy_nxt = CORDW'(y_w + SPY);
                    end
                end else if (y_w < SPY) begin
                    qy_nxt    = '0;
                    dir_y_nxt = 1'b0;
                end else begin
                    qy_nxt = CORDW'(y_w - SPY);
                end
            end
        end

        // Position state: start layout on reset, step on unpaused frame pulse
        always_ff @(posedge clk_pix or posedge rst) begin
            if (rst) begin
                qx    <= CORDW'(X0);
                qy    <= CORDW'(Y0);
                dir_x <= 1'(g % 2);
                dir_y <= 1'(g % 2);
            end else if (frame && !pause) begin
                qx    <= qx_nxt;
                qy    <= qy_nxt;
                dir_x <= dir_x_nxt;
                dir_y <= dir_y_nxt;
            end
        end

        assign hit[g] = (sx_w >= x_w) && (sx_w < x_w + Q_W) &&
                        (sy_w >= y_w) && (sy_w < y_w + Q_W);
    end

    // Lowest-index covering square wins
    always_comb begin
        win_id = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (hit[i-1]) win_id = IDW'(i - 1);
        end
    end

    assign any_hit = |hit;
    assign overlap = (hit & (hit - N'(1))) != '0;

    // Registered draw flag and winning index
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            draw    <= 1'b0;
            draw_id <= '0;
        end else begin
            draw    <= de && any_hit;
            draw_id <= (de && any_hit) ? win_id : '0;
        end
    end

`ifdef SQUARE_COLLIDE_EN
    logic overlap_acc;

    // Sticky overlap seen in active video, handed to collide on each frame pulse
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            overlap_acc <= 1'b0;
            collide     <= 1'b0;
        end else if (frame) begin
            collide     <= overlap_acc;
            overlap_acc <= de && overlap;
        end else begin
            overlap_acc <= overlap_acc | (de && overlap);
        end
    end
`else
    assign collide = 1'b0;
`endif

endmodule

// File: tb/tb_square_animator.sv
// Directed bench: one raster-wrap and one bounce instance (N=2) share stimulus.
module tb_square_animator;

    localparam int unsigned CORDW = 12;

    logic             clk_pix = 1'b0;
    logic             rst;
    logic             frame;
    logic             pause;
    logic [CORDW-1:0] sx;
    logic [CORDW-1:0] sy;
    logic             de;

    logic       r_draw, b_draw, r_collide, b_collide;
    logic [0:0] r_id, b_id;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_coll;

    always #5 clk_pix = ~clk_pix;

    square_animator #(.N(2), .MODE(0)) u_raster (
        .clk_pix(clk_pix), .rst(rst), .frame(frame), .pause(pause),
        .sx(sx), .sy(sy), .de(de),
        .draw(r_draw), .draw_id(r_id), .collide(r_collide)
    );

    square_animator #(.N(2), .MODE(1)) u_bounce (
        .clk_pix(clk_pix), .rst(rst), .frame(frame), .pause(pause),
        .sx(sx), .sy(sy), .de(de),
        .draw(b_draw), .draw_id(b_id), .collide(b_collide)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one pixel and sample the registered result just after the edge
    task automatic probe(input int x, input int y, input logic d);
        @(negedge clk_pix);
        sx    = CORDW'(x);
        sy    = CORDW'(y);
        de    = d;
        frame = 1'b0;
        @(posedge clk_pix);
        #1;
    endtask

    task automatic do_frames(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_pix);
            de    = 1'b0;
            frame = 1'b1;
            @(negedge clk_pix);
            frame = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; frame = 1'b0; pause = 1'b0; sx = '0; sy = '0; de = 1'b0;
`ifdef SQUARE_COLLIDE_EN
        exp_coll = 1'b1;
`else
        exp_coll = 1'b0;
`endif
        repeat (3) @(posedge clk_pix);
        #1;
        check("rst_draw",    4'(b_draw), 4'd0);
        check("rst_id",      4'(b_id), 4'd0);
        check("rst_collide", 4'(b_collide), 4'd0);
        @(negedge clk_pix);
        rst = 1'b0;

        // Start layout: sq0 (0,0), sq1 (192,96)
        probe(0, 0, 1'b1);
        check("start_00_draw", 4'(b_draw), 4'd1);
        check("start_00_id",   4'(b_id), 4'd0);
        check("start_00_rdraw", 4'(r_draw), 4'd1);
        probe(192, 96, 1'b1);
        check("start_sq1_draw", 4'(b_draw), 4'd1);
        check("start_sq1_id",   4'(b_id), 4'd1);
        probe(100, 0, 1'b1);
        check("start_gap_draw", 4'(b_draw), 4'd0);
        check("start_gap_id",   4'(b_id), 4'd0);
        probe(0, 0, 1'b0);
        check("de_low_draw", 4'(b_draw), 4'd0);
        check("start_collide", 4'(b_collide), 4'd0);

        // Bounce after 5 frames: sq0 (60,40), sq1 (132,56); raster sq0 (60,0)
        do_frames(5);
        probe(140, 60, 1'b1);
        check("overlap_draw", 4'(b_draw), 4'd1);
        check("overlap_id",   4'(b_id), 4'd0);
        probe(227, 151, 1'b1);
        check("sq1_corner_id", 4'(b_id), 4'd1);
        probe(228, 60, 1'b1);
        check("sq1_right_excl", 4'(b_draw), 4'd0);
        probe(60, 0, 1'b1);
        check("raster_f5_draw", 4'(r_draw), 4'd1);
        probe(59, 40, 1'b1);
        check("sq0_left_excl", 4'(b_draw), 4'd0);
        do_frames(1);
        check("collide_set", 4'(b_collide), 4'(exp_coll));
        check("raster_no_collide", 4'(r_collide), 4'd0);
        do_frames(1);
        check("collide_clear", 4'(b_collide), 4'd0);

        // After 7 frames: bounce sq0 (84,56), raster sq0 (84,0)
        probe(84, 56, 1'b1);
        check("pre_pause_b", 4'(b_draw), 4'd1);
        check("pre_pause_r", 4'(r_draw), 4'd1);
        probe(83, 56, 1'b1);
        check("pre_pause_edge_b", 4'(b_draw), 4'd0);
        check("pre_pause_edge_r", 4'(r_draw), 4'd0);
        pause = 1'b1;
        do_frames(10);
        pause = 1'b0;
        probe(84, 56, 1'b1);
        check("pause_hold_b", 4'(b_draw), 4'd1);
        check("pause_hold_r", 4'(r_draw), 4'd1);
        probe(83, 56, 1'b1);
        check("pause_edge_b", 4'(b_draw), 4'd0);
        check("pause_edge_r", 4'(r_draw), 4'd0);
        do_frames(1);
        // Bounce sq0 (96,64), sq1 (96,32); raster sq0 (96,0)
        probe(96, 130, 1'b1);
        check("resume_b_draw", 4'(b_draw), 4'd1);
        check("resume_b_id",   4'(b_id), 4'd0);
        check("resume_r_miss", 4'(r_draw), 4'd0);
        probe(95, 130, 1'b1);
        check("resume_b_edge", 4'(b_draw), 4'd0);
        probe(96, 0, 1'b1);
        check("resume_r_draw", 4'(r_draw), 4'd1);
        probe(95, 0, 1'b1);
        check("resume_r_edge", 4'(r_draw), 4'd0);

        // Reset during active video
        probe(96, 130, 1'b1);
        check("pre_rst_draw", 4'(b_draw), 4'd1);
        @(posedge clk_pix);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_draw_async", 4'(b_draw), 4'd0);
        @(posedge clk_pix);
        #1;
        check("mid_rst_draw", 4'(b_draw), 4'd0);
        check("mid_rst_collide", 4'(b_collide), 4'd0);
        @(negedge clk_pix);
        rst = 1'b0;
        probe(0, 0, 1'b1);
        check("post_rst_draw", 4'(b_draw), 4'd1);
        check("post_rst_id",   4'(b_id), 4'd0);
        check("post_rst_rdraw", 4'(r_draw), 4'd1);
        probe(192, 96, 1'b1);
        check("post_rst_sq1_id", 4'(b_id), 4'd1);

        // Edge behaviour: 152 frames puts sq0 at x=1824 in both modes
        do_frames(152);
        probe(1824, 0, 1'b1);
        check("r152_draw", 4'(r_draw), 4'd1);
        check("r152_id",   4'(r_id), 4'd0);
        probe(1823, 0, 1'b1);
        check("r152_edge", 4'(r_draw), 4'd0);
        probe(1824, 800, 1'b1);
        check("b152_draw", 4'(b_draw), 4'd1);
        check("b152_id",   4'(b_id), 4'd0);
        probe(1823, 800, 1'b1);
        check("b152_edge", 4'(b_draw), 4'd0);

        do_frames(1);
        probe(0, 96, 1'b1);
        check("r153_wrap_draw", 4'(r_draw), 4'd1);
        check("r153_wrap_id",   4'(r_id), 4'd0);
        probe(1824, 0, 1'b1);
        check("r153_old_row", 4'(r_draw), 4'd0);
        probe(1824, 800, 1'b1);
        check("b153_hold", 4'(b_draw), 4'd1);
        probe(1823, 800, 1'b1);
        check("b153_edge", 4'(b_draw), 4'd0);

        do_frames(1);
        probe(1812, 800, 1'b1);
        check("b154_back", 4'(b_draw), 4'd1);
        probe(1811, 800, 1'b1);
        check("b154_edge", 4'(b_draw), 4'd0);
        probe(12, 96, 1'b1);
        check("r154_draw", 4'(r_draw), 4'd1);
        probe(11, 96, 1'b1);
        check("r154_edge", 4'(r_draw), 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
